fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the dual-clock FIFO. It runs entirely in the write clock domain and generates the RAM write strobe and write address. It exports the Gray-coded write pointer to the read domain's two-flop pointer synchronizer. It consumes the already-synchronized Gray read pointer to produce full, almost_full, occupancy and a sticky overflow flag.

Parameters:
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 12, occupancy at or above which almost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  producer write request, one word per cycle
rd_ptr_gray_sync  in  ADDR_WIDTH+1  read pointer (Gray), already synchronized into clk domain
clr_overflow  in  1  clears sticky overflow
ram_we  out  1  RAM write enable (= wr_req & ~full)
ram_waddr  out  ADDR_WIDTH  RAM write address
wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer
full  out  1  registered full flag
almost_full  out  1  registered almost-full flag
wr_count  out  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (rst_n low, async): wr_ptr_bin, wr_ptr_gray, wr_count = 0; full, almost_full, overflow = 0. Held while rst_n low; release is synchronous to clk edge only via flops' natural behaviour (no internal resynchronizer).
- Accepted write: ram_we is combinational = wr_req & ~full, same cycle as wr_req. ram_waddr = wr_ptr_bin[ADDR_WIDTH-1:0], combinational from the register.
- On a clk edge with ram_we=1: wr_ptr_bin <= wr_ptr_bin+1, modulo 2**(ADDR_WIDTH+1). wr_ptr_gray <= bin2gray(next), registered, never combinational, so only one bit toggles per edge.
- Define next_bin = wr_ptr_bin + ram_we and next_gray = bin2gray(next_bin).
- Full: full <= (next_gray == {~rq[MSB], ~rq[MSB-1], rq[MSB-2:0]}), where rq = rd_ptr_gray_sync. Full asserts the cycle after the write that fills the FIFO. It deasserts one clk after a changed rd_ptr_gray_sync shows space.
- Occupancy: rd_bin = gray2bin(rd_ptr_gray_sync). wr_count <= next_bin - rd_bin, (ADDR_WIDTH+1)-bit modular subtraction. The value is pessimistic (stale read pointer) and never under-reports.
- almost_full <= (next_bin - rd_bin) >= AFULL_THRESH.
- Overflow: set when wr_req & full. Cleared when clr_overflow. Simultaneous set and clear: set wins. A dropped write does not advance the pointer or assert ram_we.
- Wrap-around: the pointer MSB toggles every 2**ADDR_WIDTH writes, and the full/count math is correct across the wrap. Boundary values are 0→31→0 for ADDR_WIDTH=4.
- Stale or illegal Gray input (multi-bit change) is not checked. Correctness relies on the upstream synchronizer seeing single-bit changes.
- Reset mid-operation: all state clears immediately. The read domain must be reset concurrently; this is a system-level requirement, not enforced here.
- No combinational path from rd_ptr_gray_sync to any output.

Decomposition:
- Shared package fifo_pkg:
  - function bin2gray(bin) and function gray2bin(gray), parameterized by pointer width.
  - localparam PTR_W = ADDR_WIDTH+1 convention.
  - The DEPTH constant.
  - Reused by the mirror fifo_rd_ctrl.
- One natural sub-module: ptr_gray_dec, a combinational Gray-to-binary decoder (XOR prefix chain). It is instantiated for rd_ptr_gray_sync and shared with fifo_rd_ctrl.

Test Plan:
- Reset: rst_n low mid-burst with wr_ptr=7 -> all outputs 0 immediately, without waiting for a clk edge; first write after release uses ram_waddr=0.
- Fill: rd_ptr_gray_sync=0, 16 back-to-back wr_req -> ram_waddr 0..15, full=1 one cycle after the 16th write, wr_count=16, wr_ptr_gray=5'b11000.
- Overflow: while full, wr_req=1 for 1 cycle -> ram_we=0, pointer unchanged, overflow=1. Then clr_overflow together with another wr_req -> overflow stays 1. clr_overflow alone -> 0.
- Drain visibility: full, then rd_ptr_gray_sync stepped to gray(4)=5'b00110 -> full=0 next cycle, wr_count=12, almost_full=1. Step to gray(5) -> wr_count=11, almost_full=0.
- Wrap: 40 writes interleaved with the read pointer trailing by 3 -> wr_ptr wraps 31→0, full never asserts, wr_count=3 steady, Gray output changes exactly one bit per accepted write.
- Simultaneous: write accepted on the same cycle rd_ptr_gray_sync advances by one at count=15 -> count stays 15, full stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for the dual-clock FIFO controllers.
package fifo_pkg;

  localparam int ADDR_WIDTH_DFLT = 4;
  localparam int PTR_W_DFLT      = ADDR_WIDTH_DFLT + 1;
  localparam int DEPTH           = 2 ** ADDR_WIDTH_DFLT;

  // Helpers work on a wide word so any pointer width up to 32 can use them;
  // callers zero-extend in and truncate out.
  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_gray_dec.sv
// Combinational Gray-to-binary pointer decoder (XOR prefix from the MSB down).
module ptr_gray_dec
  import fifo_pkg::*;
#(
  parameter int W = PTR_W_DFLT
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the dual-clock FIFO (write domain).
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DFLT,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  input  logic                  clr_overflow,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int MSB   = PTR_W - 1;
  localparam logic [PTR_W-1:0] AFULL_T = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wr_ptr_bin_q,  wr_ptr_bin_d;
  logic [PTR_W-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PTR_W-1:0] wr_count_q,    wr_count_d;
  logic             full_q,        full_d;
  logic             afull_q,       afull_d;
  logic             overflow_q,    overflow_d;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] full_cmp;

  ptr_gray_dec #(.W(PTR_W)) u_rd_dec (
    .gray_i (rd_ptr_gray_sync),
    .bin_o  (rd_bin)
  );

  // Writes are accepted only while not full; the address comes straight from the pointer register.
  assign ram_we    = wr_req & ~full_q;
  assign ram_waddr = wr_ptr_bin_q[ADDR_WIDTH-1:0];

  // Next pointer, its Gray form, and the flags derived from it against the synced read pointer.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    wr_ptr_bin_d  = wr_ptr_bin_q + {{(PTR_W-1){1'b0}}, ram_we};
    wr_ptr_gray_d = PTR_W'(bin2gray(ptr_word_t'(wr_ptr_bin_d)));
    // Full in Gray space: top two bits inverted, the rest equal, means a whole depth ahead.
    full_cmp      = {~rd_ptr_gray_sync[MSB], ~rd_ptr_gray_sync[MSB-1], rd_ptr_gray_sync[MSB-2:0]};
    full_d        = (wr_ptr_gray_d == full_cmp);
    // Modular difference is correct across the pointer wrap; stale rd_bin only over-reports.
    wr_count_d    = wr_ptr_bin_d - rd_bin;
    afull_d       = (wr_count_d >= AFULL_T);
    // A new dropped write wins over a clear issued in the same cycle.
    overflow_d    = (wr_req & full_q) | (overflow_q & ~clr_overflow);
  end

  // State registers; Gray pointer is registered so the read domain sees one-bit steps only.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: asynchronous reset clears every flop at once, with no clock edge required.
    if (!rst_n) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      afull_q       <= afull_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: occupancy model in plain integers plus directed literals.
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [AW:0]   rd_ptr_gray_sync;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  // Read side is represented as a plain count of words consumed.
  int rd_total = 0;
  assign rd_ptr_gray_sync = 5'(((rd_total % 32) ^ ((rd_total % 32) >> 1)));

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFULL)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_req           (wr_req),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .clr_overflow     (clr_overflow),
    .ram_we           (ram_we),
    .ram_waddr        (ram_waddr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .wr_count         (wr_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: total words written and read as unbounded integers; occupancy is their difference.
  int m_wr   = 0;
  int m_cnt  = 0;
  bit m_full = 0;
  bit m_afull = 0;
  bit m_ovf  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; m_cnt = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      bit acc, ovf_n;
      acc   = wr_req && !m_full;
      ovf_n = (wr_req && m_full) || (m_ovf && !clr_overflow);
      m_wr  = m_wr + (acc ? 1 : 0);
      m_cnt = m_wr - rd_total;
      m_full  = (m_cnt == DEPTH);
      m_afull = (m_cnt >= AFULL);
      m_ovf   = ovf_n;
    end
  end

  function automatic logic [31:0] gray_of(input int n);
    int b;
    b = n % 32;
    return 32'(b ^ (b >> 1));
  endfunction

  // Compare every cycle on the falling edge, away from the active edge and input changes.
  always @(negedge clk) begin
    check("m_ram_we",      32'(ram_we),      32'(wr_req && !m_full));
    check("m_ram_waddr",   32'(ram_waddr),   32'(m_wr % DEPTH));
    check("m_wr_ptr_gray", 32'(wr_ptr_gray), gray_of(m_wr));
    check("m_full",        32'(full),        32'(m_full));
    check("m_almost_full", 32'(almost_full), 32'(m_afull));
    check("m_wr_count",    32'(wr_count),    32'(m_cnt));
    check("m_overflow",    32'(overflow),    32'(m_ovf));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW:0] prev_gray;

    // Power-on reset.
    #2;
    check("rst_gray",  32'(wr_ptr_gray), 32'h0);
    check("rst_count", 32'(wr_count),    32'h0);
    check("rst_full",  32'(full),        32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Seven writes, then asynchronous reset between clock edges.
    wr_req = 1'b1;
    repeat (7) cyc();
    check("pre_rst_waddr", 32'(ram_waddr), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_waddr", 32'(ram_waddr),   32'h0);
    check("async_rst_gray",  32'(wr_ptr_gray), 32'h0);
    check("async_rst_count", 32'(wr_count),    32'h0);
    check("async_rst_afull", 32'(almost_full), 32'h0);
    check("async_rst_ovf",   32'(overflow),    32'h0);
    wr_req = 1'b0;
    rd_total = 0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Fill sixteen words with the reader idle at 0.
    wr_req = 1'b1;
    #1;
    check("first_waddr", 32'(ram_waddr), 32'h0);
    check("first_we",    32'(ram_we),    32'h1);
    repeat (16) cyc();
    check("fill_full",  32'(full),        32'h1);
    check("fill_count", 32'(wr_count),    32'd16);
    check("fill_gray",  32'(wr_ptr_gray), 32'b11000);
    check("fill_afull", 32'(almost_full), 32'h1);

    // Write attempt while full.
    check("ovf_we_blocked", 32'(ram_we), 32'h0);
    cyc();
    check("ovf_set",       32'(overflow),    32'h1);
    check("ovf_ptr_held",  32'(wr_ptr_gray), 32'b11000);
    clr_overflow = 1'b1;
    cyc();
    check("ovf_set_wins", 32'(overflow), 32'h1);
    wr_req = 1'b0;
    cyc();
    check("ovf_cleared", 32'(overflow), 32'h0);
    clr_overflow = 1'b0;

    // Reader frees space.
    rd_total = 4;
    #1;
    check("rd_gray4", 32'(rd_ptr_gray_sync), 32'b00110);
    cyc();
    check("drain_full",  32'(full),        32'h0);
    check("drain_count", 32'(wr_count),    32'd12);
    check("drain_afull", 32'(almost_full), 32'h1);
    rd_total = 5;
    cyc();
    check("drain5_count", 32'(wr_count),    32'd11);
    check("drain5_afull", 32'(almost_full), 32'h0);

    // Bring count to 15, then write and read in the same cycle.
    wr_req = 1'b1;
    repeat (4) cyc();
    check("pre_sim_count", 32'(wr_count), 32'd15);
    rd_total = 6;
    cyc();
    check("sim_count", 32'(wr_count), 32'd15);
    check("sim_full",  32'(full),     32'h0);
    wr_req = 1'b0;

    // Reader catches up to trail by three (21 written).
    while (rd_total < 18) begin
      rd_total++;
      cyc();
    end
    check("trail_count", 32'(wr_count), 32'd3);

    // Forty writes with the reader trailing by three; pointer wraps 31 -> 0.
    for (int i = 0; i < 40; i++) begin
      prev_gray = wr_ptr_gray;
      wr_req = 1'b1;
      rd_total++;
      cyc();
      check("wrap_count", 32'(wr_count), 32'd3);
      check("wrap_full",  32'(full),     32'h0);
      check("wrap_gray_1bit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'd1);
    end
    wr_req = 1'b0;
    check("wrap_final_gray", 32'(wr_ptr_gray), 32'b10011);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
